// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, data width.
package lsu_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_e;

   // Size code 11 behaves as a word, so bit 1 alone identifies word accesses.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        offset,
   input  logic [1:0]        size,
   input  logic              sgn,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merge_data
);

   logic [4:0]        sh;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;

   assign sh = {offset, 3'b000};

   // Shift the addressed lane down for loads, and build a lane mask for merging stores.
   always_comb begin
      shifted   = word >> sh;
      mask      = '1;
      load_data = word;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            mask      = 32'h0000_00FF;
         end
         SZ_HALF: begin
            load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            mask      = 32'h0000_FFFF;
         end
         default: begin
            load_data = word;
            mask      = '1;
         end
      endcase
      mask       = mask << sh;
      merge_data = (word & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-addressed synchronous data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests return resp_err
// without touching memory; otherwise low address bits are forced to alignment.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   import lsu_pkg::*;

   state_e            state;
   logic              op_we;
   logic [1:0]        op_size;
   logic              op_sgn;
   logic [1:0]        op_off;
   logic [DATA_W-1:0] op_wdata;
   logic [1:0]        off_al;
   logic              mis;
   logic [DATA_W-1:0] lane_load;
   logic [DATA_W-1:0] lane_merge;

`ifdef LSU_MISALIGN_TRAP_EN
   assign off_al = req_addr[1:0];
   assign mis    = ((req_size == SZ_HALF) && req_addr[0]) ||
                   (is_word(req_size) && (req_addr[1:0] != 2'b00));
`else
   assign off_al = is_word(req_size)   ? 2'b00 :
                   (req_size == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];
   assign mis    = 1'b0;
`endif

   lsu_byte_lane u_lane (
      .word       (read_data),
      .wdata      (op_wdata),
      .offset     (op_off),
      .size       (op_size),
      .sgn        (op_sgn),
      .load_data  (lane_load),
      .merge_data (lane_merge)
   );

   // Request sequencer; all handshake and memory outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         address    <= '0;
         write_data <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         op_we      <= 1'b0;
         op_size    <= SZ_BYTE;
         op_sgn     <= 1'b0;
         op_off     <= 2'b00;
         op_wdata   <= '0;
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_we      <= req_we;
                  op_size    <= req_size;
                  op_sgn     <= req_signed;
                  op_off     <= off_al;
                  op_wdata   <= req_wdata;
                  address    <= req_addr >> 2;
                  resp_rdata <= '0;
                  resp_err   <= mis;
                  req_ready  <= 1'b0;
                  if (mis) begin
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else if (req_we && is_word(req_size)) begin
                     write_data <= req_wdata;
                     mem_write  <= 1'b1;
                     state      <= WR;
                  end else begin
                     mem_read <= 1'b1;
                     state    <= RD;
                  end
               end
            end
            RD: state <= CAP;
            CAP: begin
               if (op_we) begin
                  write_data <= lane_merge;
                  mem_write  <= 1'b1;
                  state      <= WR;
               end else begin
                  resp_rdata <= lane_load;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WR: begin
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand sequences, randomized vs byte-level model.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] write_data;
   logic [31:0] read_data = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [16];
   logic [7:0]  ref_b [64];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          pre_idx;
      logic [31:0] pre_val;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .address    (address),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .write_data (write_data),
      .read_data  (read_data)
   );

   // Synchronous word memory: read data appears the cycle after mem_read.
   always @(posedge clk) begin
      if (mem_read) read_data <= mem[int'(address % 16)];
      if (mem_write) mem[int'(address % 16)] = write_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int pre_idx, input logic [31:0] pre_val,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_rd, input int exp_wr,
                               input logic [31:0] exp_wd);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.pre_idx = pre_idx; v.pre_val = pre_val; v.exp_rdata = exp_rdata;
      v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rd = exp_rd;
      v.exp_wr = exp_wr; v.exp_wd = exp_wd;
      return v;
   endfunction

   // Byte-level model: effective address, bytes moved, extension, and expected timing.
   task automatic ref_op(inout vec_t v);
      int n, ea;
      logic mis;
      logic [31:0] val;
      n   = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
      mis = (v.addr % n) != 0;
      ea  = int'(v.addr - (v.addr % n));
      v.pre_idx = -1; v.pre_val = '0;
      v.exp_rdata = '0; v.exp_err = 1'b0; v.exp_wd = '0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) begin
         v.exp_err = 1'b1; v.exp_lat = 1; v.exp_rd = 0; v.exp_wr = 0;
         return;
      end
`else
      if (mis) ea = ea;
`endif
      if (!v.we) begin
         val = '0;
         for (int i = 0; i < n; i++) val = val | (32'(ref_b[ea + i]) << (8 * i));
         if (v.sgn && n < 4 && val[8 * n - 1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
         v.exp_rdata = val; v.exp_lat = 3; v.exp_rd = 1; v.exp_wr = 0;
      end else begin
         for (int i = 0; i < n; i++) ref_b[ea + i] = 8'(v.wdata >> (8 * i));
         val = '0;
         for (int i = 0; i < 4; i++) val = val | (32'(ref_b[(ea & ~3) + i]) << (8 * i));
         v.exp_wd = val; v.exp_wr = 1;
         v.exp_lat = (n == 4) ? 2 : 4;
         v.exp_rd  = (n == 4) ? 0 : 1;
      end
   endtask

   // Issue one request, observe strobes cycle by cycle, check the response and its stall behaviour.
   task automatic run_vec(input vec_t v, input int stall, input string tag);
      int cyc, nrd, nwr;
      logic ovl, addr_bad;
      logic [31:0] swd;
      if (v.pre_idx >= 0) mem[v.pre_idx] = v.pre_val;
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; resp_ready = (stall == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1; nrd = 0; nwr = 0; ovl = 1'b0; addr_bad = 1'b0; swd = '0;
      forever begin
         if (mem_read && mem_write) ovl = 1'b1;
         if (mem_read) begin
            nrd++;
            if (address != (v.addr >> 2)) addr_bad = 1'b1;
         end
         if (mem_write) begin
            nwr++;
            swd = write_data;
            if (address != (v.addr >> 2)) addr_bad = 1'b1;
         end
         if (resp_valid) break;
         if (cyc >= 20) begin
            check({tag, ".timeout"}, 32'(resp_valid), 32'd1);
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".latency"}, 32'(cyc), 32'(v.exp_lat));
      check({tag, ".rdata"}, resp_rdata, v.exp_rdata);
      check({tag, ".err"}, 32'(resp_err), 32'(v.exp_err));
      check({tag, ".reads"}, 32'(nrd), 32'(v.exp_rd));
      check({tag, ".writes"}, 32'(nwr), 32'(v.exp_wr));
      check({tag, ".overlap"}, 32'(ovl), 32'd0);
      check({tag, ".addr"}, 32'(addr_bad), 32'd0);
      if (v.exp_wr > 0) check({tag, ".wdata"}, swd, v.exp_wd);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".stall_rdata"}, resp_rdata, v.exp_rdata);
         check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
      check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
      $display("%s we=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
               tag, v.we, v.size, v.sgn, v.addr, v.wdata, resp_rdata, resp_err, cyc, nrd, nwr);
   endtask

   initial begin
      vec_t v;
      int seen;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Directed vectors with hand-derived expectations.
      tbl[0]  = mk(0, 2'b10, 0, 32'h4, 0, 1, 32'h1234_5678, 32'h1234_5678, 0, 3, 1, 0, 0);
      tbl[1]  = mk(0, 2'b00, 1, 32'h7, 0, 1, 32'h80FF_0000, 32'hFFFF_FF80, 0, 3, 1, 0, 0);
      tbl[2]  = mk(0, 2'b00, 0, 32'h7, 0, -1, 0, 32'h0000_0080, 0, 3, 1, 0, 0);
      tbl[3]  = mk(0, 2'b01, 1, 32'h4, 0, -1, 0, 32'h0000_0000, 0, 3, 1, 0, 0);
      tbl[4]  = mk(0, 2'b01, 1, 32'h6, 0, -1, 0, 32'hFFFF_80FF, 0, 3, 1, 0, 0);
      tbl[5]  = mk(1, 2'b01, 0, 32'h6, 32'h0000_BEEF, 1, 32'h1234_5678, 0, 0, 4, 1, 1, 32'hBEEF_5678);
      tbl[6]  = mk(0, 2'b10, 0, 32'h4, 0, -1, 0, 32'hBEEF_5678, 0, 3, 1, 0, 0);
      tbl[7]  = mk(1, 2'b10, 0, 32'h8, 32'hCAFE_F00D, -1, 0, 0, 0, 2, 0, 1, 32'hCAFE_F00D);
      tbl[8]  = mk(0, 2'b11, 0, 32'h8, 0, -1, 0, 32'hCAFE_F00D, 0, 3, 1, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[9]  = mk(0, 2'b01, 1, 32'h3, 0, 0, 32'hA1B2_C3D4, 0, 1, 1, 0, 0, 0);
`else
      tbl[9]  = mk(0, 2'b01, 1, 32'h3, 0, 0, 32'hA1B2_C3D4, 32'hFFFF_A1B2, 0, 3, 1, 0, 0);
`endif
      tbl[10] = mk(1, 2'b00, 0, 32'h1, 32'hFFFF_FF5A, -1, 0, 0, 0, 4, 1, 1, 32'hA1B2_5AD4);
      tbl[11] = mk(0, 2'b10, 0, 32'h0, 0, -1, 0, 32'hA1B2_5AD4, 0, 3, 1, 0, 0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_err", 32'(resp_err), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.address", address, 32'd0);
      check("rst.write_data", write_data, 32'd0);
      check("rst.strobes", {30'd0, mem_read, mem_write}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

      // Stalled response: data held, not ready for new work.
      run_vec(mk(0, 2'b00, 1, 32'h2, 0, 0, 32'h0055_0000, 32'h0000_0055, 0, 3, 1, 0, 0), 3, "stall");

      // Reset while RD is active aborts the request.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h4;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort.in_rd", 32'(mem_read), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort.strobes", {30'd0, mem_read, mem_write}, 32'd0);
      check("abort.req_ready", 32'(req_ready), 32'd1);
      check("abort.resp_valid", 32'(resp_valid), 32'd0);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (resp_valid || mem_read || mem_write) seen++;
      end
      check("abort.quiet", 32'(seen), 32'd0);
      $display("abort reset_during_rd activity=%0d", seen);

      // Randomized traffic against the byte-level model.
      for (int w = 0; w < 16; w++) begin
         mem[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_b[4 * w + b] = 8'(mem[w] >> (8 * b));
      end
      for (int t = 0; t < 40; t++) begin
         v.we    = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 3));
         v.sgn   = 1'($urandom_range(0, 1));
         v.addr  = 32'($urandom_range(0, 63));
         v.wdata = $urandom;
         ref_op(v);
         run_vec(v, int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store initiator that drives the word-addressed `DataMemory` responder on behalf of the CPU datapath. It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It issues the matching `mem_read`/`mem_write` strobe sequence, including read-modify-write for sub-word stores, and returns sign- or zero-extended load data on a response handshake. It sits between the execute/memory pipeline stage and the data memory.

## Interface
- ADDR_W, 32, byte-address width of requests and memory address.
- DATA_W, 32, data width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and accepting.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- req_signed  in  1  sign-extend loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  misaligned request.
- address  out  ADDR_W  word index to memory, equal to req_addr >> 2.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- write_data  out  DATA_W  word written to memory.
- read_data  in  DATA_W  memory word; valid on the clock edge one cycle after mem_read.

## Operation
- **Byte lanes.** Lanes are little-endian: byte offset 0 maps to bits [7:0]. A halfword at offset 2 maps to bits [31:16].
- **Request latching.** A request is accepted on the clock edge where req_valid && req_ready. Address, size, signed, we and wdata are latched at that edge.
- **IDLE.** req_ready = 1.
  - Misaligned request (half with addr[0] = 1, or word with addr[1:0] != 0) goes to RESP with resp_err = 1.
  - Word store goes to WR.
  - All other requests go to RD.
- **RD.** mem_read = 1 for exactly one cycle; next state CAP.
- **CAP.** read_data is captured.
  - Load: resp_rdata is formed by extracting the lane and applying sign or zero extension; next state RESP.
  - Sub-word store: the captured word is merged with the store lane; next state WR.
- **WR.** mem_write = 1 for exactly one cycle with the merged word (or req_wdata for a word store); next state RESP.
- **RESP.** resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready = 1; then the state returns to IDLE.
- **Strobes.**
  - mem_read and mem_write are never asserted together.
  - Both are 0 in IDLE and RESP.
  - address is held constant from RD through WR.
- **Back-to-back requests.** A new request is accepted no earlier than the cycle after RESP completes.
- **Reset.**
  - On the edge where rst = 0, the state goes to IDLE.
  - Reset values: resp_valid 0, resp_err 0, resp_rdata 0, address 0, write_data 0, mem_read 0, mem_write 0, req_ready 1.
  - A strobe already driven during the reset cycle takes effect at the memory; no further strobe is issued.
  - An aborted request produces no response.

## Timing
- Latency counts from the accept edge (cycle 0) to the first resp_valid cycle.
  - Word store: 2 (WR at cycle 1).
  - Load of any size: 3 (RD at 1, CAP at 2).
  - Sub-word store: 4 (RD, CAP, WR).
  - Misaligned request (macro on): 1.
- All outputs are registered or decoded from state only. There is no combinational path from req_* to any mem_* output.
- Throughput is one request per latency + 1 cycles when resp_ready is held at 1.

## Configuration
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned requests go straight to RESP with resp_err = 1, no mem strobes and resp_rdata 0.
  - Undefined: addr low bits are forced to the size's natural alignment (half clears bit 0; word clears bits [1:0]) and the access proceeds normally. resp_err is tied to 0.

## Structure
- lsu_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, RD, CAP, WR, RESP);
  - the DATA_W constant.
- Sub-module lsu_byte_lane is purely combinational and does two things:
  - load extract and extend, from (word, offset, size, signed);
  - store merge, from (old word, wdata, offset, size).

## Test plan
- **Word load.** Reset, memory word 1 = 0x12345678; load word at 0x4 → address = 1, mem_read at cycle 1, resp_rdata = 0x12345678 with resp_valid at cycle 3.
- **Byte load, signed and unsigned.** Word 1 = 0x80FF0000; signed byte load at 0x7 → 0xFFFFFF80; unsigned → 0x00000080; signed half load at 0x4 → 0x00000000.
- **Halfword store (read-modify-write).** Word 1 = 0x12345678; store half 0xBEEF at 0x6 → one mem_read, then one mem_write with write_data = 0xBEEF5678; subsequent word load at 0x4 returns 0xBEEF5678.
- **Word store.** Store word 0xCAFEF00D at 0x8 → no mem_read, mem_write at cycle 1 with address = 2, resp_valid at cycle 2.
- **Misaligned half load at 0x3.**
  - Macro on: resp_err = 1 at cycle 1 and no strobes.
  - Macro off: read at address 0, data from offset 2.
- **Stall and reset.**
  - Hold resp_ready = 0 for 3 cycles → resp_valid and data stable, req_ready = 0.
  - Drive rst = 0 during RD → next cycle: strobes 0, req_ready 1, no response.
